// File: rtl/led_trail_pwm_if.sv
// Signal bundle between the chaser-side driver and the LED trail/PWM stage.
// The driver (master) supplies run enable and the light vector; the trail
// stage (slave) returns the LED drive, the PWM period marker and activity.
interface led_trail_pwm_if #(
    parameter int N_LEDS = 8
);
    logic              enable;
    logic [N_LEDS-1:0] light_in;
    logic [N_LEDS-1:0] led_out;
    logic              pwm_sync;
    logic              active;

    modport master (
        output enable,
        output light_in,
        input  led_out,
        input  pwm_sync,
        input  active
    );

    modport slave (
        input  enable,
        input  light_in,
        output led_out,
        output pwm_sync,
        output active
    );
endinterface

// File: rtl/led_trail_pwm.sv
// LED comet-trail renderer: each lit input snaps its channel to full
// brightness, unlit channels fade one level per decay tick, and a shared
// free-running PWM counter turns the per-channel level into a pin duty.

// One LED channel: brightness level register plus its registered PWM pin.
module led_trail_chan #(
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               decay_tick,
    input  logic               light,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic [LEVEL_W-1:0] level,
    output logic               led
);
    localparam logic [LEVEL_W-1:0] MAX = '1;

    // Level: load to MAX while lit (wins over a decay tick), else step down
    // toward zero on each decay tick; frozen while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (enable) begin
            if (light) begin
                level <= MAX;
            end else if (decay_tick && (level != '0)) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    // Pin drive: MAX forces a solid 100% duty, otherwise on while the
    // level is above the PWM phase; dark whenever the block is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 1'b0;
        end else begin
            led <= enable && ((level == MAX) || (level > pwm_cnt));
        end
    end
endmodule

module led_trail_pwm #(
    parameter int N_LEDS    = 8,
    parameter int LEVEL_W   = 4,
    parameter int DECAY_DIV = 16
) (
    input logic              clk,
    input logic              rst,
    led_trail_pwm_if.slave   bus
);
    // A divider of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int                DCNT_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 1);

    logic [LEVEL_W-1:0]             pwm_cnt;
    logic [DCNT_W-1:0]              dcnt;
    logic                           decay_tick;
    logic                           pwm_sync;
    logic [N_LEDS-1:0][LEVEL_W-1:0] level;
    logic [N_LEDS-1:0]              led;
    logic [N_LEDS-1:0]              lit;

    // PWM phase: free-running, wraps MAX->0 by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
        end else if (bus.enable) begin
            pwm_cnt <= pwm_cnt + LEVEL_W'(1);
        end
    end

    // Decay prescaler: counts 0..DECAY_DIV-1 on enabled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
        end else if (bus.enable) begin
            dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_W'(1);
        end
    end

    assign decay_tick = bus.enable && (dcnt == DCNT_LAST);

    // Period marker: one pulse in the cycle that renders phase 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_sync <= 1'b0;
        end else begin
            pwm_sync <= bus.enable && (pwm_cnt == '0);
        end
    end

    for (genvar g = 0; g < N_LEDS; g++) begin : g_chan
        led_trail_chan #(
            .LEVEL_W (LEVEL_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .enable     (bus.enable),
            .decay_tick (decay_tick),
            .light      (bus.light_in[g]),
            .pwm_cnt    (pwm_cnt),
            .level      (level[g]),
            .led        (led[g])
        );
        assign lit[g] = |level[g];
    end

    assign bus.led_out  = led;
    assign bus.pwm_sync = pwm_sync;
    assign bus.active   = |lit;
endmodule
